apb_lsu_bridge: RTL

- Upstream neighbour of the APB SRAM slave: converts single-outstanding CPU load/store requests into APB setup/access transfers.
- Drives paddr/pwdata/pstb/psel/penable/pwrite, consumes prdata/pready/perr.
- Returns an aligned, sign/zero-extended load result or an error cause to the core.
- Handles byte/half/word sizing, misalignment rejection and a bus timeout.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/apb_lsu_bridge_if.sv | 41 ++++
 rtl/lsu_align.sv | 46 ++++
 rtl/apb_lsu_bridge.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store to APB bridge
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] CAUSE_OK       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/apb_lsu_bridge_if.sv
// rtl/apb_lsu_bridge_if.sv - core request/response and APB signal bundle
interface apb_lsu_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;

    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_cause;

    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [3:0]            pstb;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  perr;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned,
        input  prdata, pready, perr,
        output req_ready, rsp_valid, rsp_rdata, rsp_cause,
        output paddr, pwdata, pstb, psel, penable, pwrite
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned,
        output prdata, pready, perr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_cause,
        input  paddr, pwdata, pstb, psel, penable, pwrite
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane strobes, misalign check, store replication, load extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_strb,
    output logic        o_misalign,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;

    always_comb begin
        o_strb     = 4'b0000;
        o_misalign = 1'b0;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        w_lane     = i_rdata >> {i_addr_lo, 3'b000};
        case (i_size)
            SZ_BYTE: begin
                o_strb  = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_lane[7]}}, w_lane[7:0]};
            end
            SZ_HALF: begin
                o_misalign = i_addr_lo[0];
                o_strb     = 4'b0011 << i_addr_lo;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{~i_unsigned & w_lane[15]}}, w_lane[15:0]};
            end
            SZ_WORD: begin
                o_misalign = |i_addr_lo;
                o_strb     = 4'b1111;
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/apb_lsu_bridge.sv
// rtl/apb_lsu_bridge.sv - single-outstanding CPU load/store to APB setup/access bridge
module apb_lsu_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_lsu_bridge_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t            r_state;
    lsu_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [3:0]            r_pstb;
    logic                  r_pwrite;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_cause;
    logic [CW-1:0]         r_cnt;

    logic [CW-1:0]         w_cnt_inc;
    logic                  w_timeout;
    logic [1:0]            w_al_addr;
    logic [1:0]            w_al_size;
    logic                  w_al_unsigned;
    logic [3:0]            w_strb;
    logic                  w_misalign;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ld_data;

    // In IDLE the aligner sees the incoming request; afterwards the latched one, for load return.
    assign w_al_addr     = (r_state == ST_IDLE) ? bus.req_addr[1:0] : r_paddr[1:0];
    assign w_al_size     = (r_state == ST_IDLE) ? bus.req_size      : r_size;
    assign w_al_unsigned = (r_state == ST_IDLE) ? bus.req_unsigned  : r_unsigned;

    lsu_align u_align (
        .i_addr_lo  (w_al_addr),
        .i_size     (w_al_size),
        .i_unsigned (w_al_unsigned),
        .i_wdata    (bus.req_wdata),
        .i_rdata    (bus.prdata),
        .o_strb     (w_strb),
        .o_misalign (w_misalign),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ld_data)
    );

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_timeout = (w_cnt_inc == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = w_misalign ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.pready || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rdata    <= '0;
            r_pstb     <= '0;
            r_pwrite   <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_cause    <= CAUSE_OK;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_paddr    <= bus.req_addr;
                        r_pwdata   <= w_wdata;
                        r_pwrite   <= bus.req_write;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_pstb     <= w_misalign ? 4'b0000 : w_strb;
                        r_cause    <= w_misalign ? CAUSE_MISALIGN : CAUSE_OK;
                        r_rdata    <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        r_pstb  <= '0;
                        r_cnt   <= '0;
                        r_cause <= bus.perr ? CAUSE_BUSERR : CAUSE_OK;
                        r_rdata <= (bus.perr || r_pwrite) ? '0 : w_ld_data;
                    end else if (w_timeout) begin
                        r_pstb  <= '0;
                        r_cnt   <= '0;
                        r_cause <= CAUSE_TIMEOUT;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RESP: begin
                    r_cause <= CAUSE_OK;
                    r_rdata <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = presetn && (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_cause = r_cause;
    assign bus.psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign bus.penable   = (r_state == ST_ACCESS);
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pstb      = r_pstb;
    assign bus.pwrite    = r_pwrite;

endmodule
